mult_ctrl: RTL and testbench

Sequencing controller for the Multiplier_P shift-add multiplier. It captures two unsigned WIDTH-bit operands on a start request. It then steps the add/shift datapath (multiplicand register, multiplier/low-product shift register, high accumulator) for exactly WIDTH iterations and presents a 2·WIDTH-bit product with a one-cycle done pulse. It is the block that drives the Mreg-style registers in the multiplier; the datapath registers live inside it so the product can be checked directly.

---
 rtl/mult_ctrl_if.sv | 24 ++
 rtl/mult_ctrl.sv | 90 +++++++++
 tb/tb_mult_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_if.sv
// rtl/mult_ctrl_if.sv - start/operand/result bundle for the shift-add multiplier controller
interface mult_ctrl_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [CW-1:0]        step;

  modport master (
    output start, a_in, b_in,
    input  busy, done, product, step
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, product, step
  );
endinterface

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - shift-add multiplier sequencer with internal A/{C,H,L} datapath
module mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  mult_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     h_reg;
  logic [WIDTH-1:0]     l_reg;
  logic                 c_reg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_reg;
  logic [WIDTH:0]       sum;
  logic                 last_iter;

  // C is always cleared by the shift, so folding it into the add keeps the sum exact
  assign sum       = {c_reg, h_reg} + {1'b0, (l_reg[0] ? a_reg : {WIDTH{1'b0}})};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == S_CALC) || (state == S_DONE);
    bus.done    = (state == S_DONE);
    bus.product = product_reg;
    bus.step    = cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      h_reg       <= '0;
      l_reg       <= '0;
      c_reg       <= 1'b0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a_in;
            l_reg <= bus.b_in;
            h_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
          end
        end
        S_CALC: begin
          // {C,H,L} <= {0,sum,L} >> 1
          c_reg <= 1'b0;
          h_reg <= sum[WIDTH:1];
          l_reg <= {sum[0], l_reg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            product_reg <= {sum, l_reg[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - randomized self-checking bench for mult_ctrl at WIDTH=8 and WIDTH=4
module tb_mult_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_ctrl_if #(.WIDTH(8)) bus8 ();
  mult_ctrl_if #(.WIDTH(4)) bus4 ();

  mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int          total = 0;
  int          bad   = 0;
  bit          sel4  = 1'b0;
  logic [31:0] last_prod [2];

  logic        cur_busy;
  logic        cur_done;
  logic [31:0] cur_prod;
  logic [31:0] cur_step;

  always_comb begin
    if (sel4) begin
      cur_busy = bus4.busy;
      cur_done = bus4.done;
      cur_prod = 32'(bus4.product);
      cur_step = 32'(bus4.step);
    end else begin
      cur_busy = bus8.busy;
      cur_done = bus8.done;
      cur_prod = 32'(bus8.product);
      cur_step = 32'(bus8.step);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (w=%0d t=%0t)", tag, got, exp, sel4 ? 4 : 8, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b);
    bus8.start = sel4 ? 1'b0 : s;
    bus8.a_in  = a[7:0];
    bus8.b_in  = b[7:0];
    bus4.start = sel4 ? s : 1'b0;
    bus4.a_in  = a[3:0];
    bus4.b_in  = b[3:0];
  endtask

  // Called at a negedge with the DUT idle; start is presented now and accepted at the next edge.
  // mode 0: start dropped, operands scrambled; 1: random start/operand noise; 2: start held with same operands
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int mode);
    int          w;
    int          lat;
    logic [31:0] exp;
    logic [31:0] prev;
    w    = sel4 ? 4 : 8;
    lat  = -1;
    exp  = 32'(a) * 32'(b);
    prev = last_prod[sel4];
    drive(1'b1, a, b);
    for (int i = 0; i <= w + 1; i++) begin
      @(negedge clk);
      if (cur_done && lat < 0) lat = i;
      if (i < w) begin
        check_eq("calc_busy", 32'(cur_busy), 32'd1);
        check_eq("calc_done", 32'(cur_done), 32'd0);
        check_eq("calc_hold", cur_prod, prev);
        check_eq("calc_step", cur_step, 32'(i));
      end else if (i == w) begin
        check_eq("done_pulse", 32'(cur_done), 32'd1);
        check_eq("done_busy", 32'(cur_busy), 32'd1);
        check_eq("product", cur_prod, exp);
        check_eq("done_step", cur_step, 32'(w));
      end else begin
        check_eq("idle_done", 32'(cur_done), 32'd0);
        check_eq("idle_busy", 32'(cur_busy), 32'd0);
        check_eq("idle_prod", cur_prod, exp);
        check_eq("idle_step", cur_step, 32'(w));
      end
      if (mode == 2) drive(1'b1, a, b);
      else if (i <= w && mode == 1) drive(1'($urandom), 16'($urandom), 16'($urandom));
      else drive(1'b0, 16'($urandom), 16'($urandom));
    end
    check_eq("latency", 32'(lat), 32'(w));
    last_prod[sel4] = exp;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("gap_busy", 32'(cur_busy), 32'd0);
      check_eq("gap_done", 32'(cur_done), 32'd0);
      check_eq("gap_prod", cur_prod, last_prod[sel4]);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    reset = 1'b1;
    drive(1'b1, 16'hFF, 16'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel4 = bit'(s);
      #0;
      check_eq("rst_busy", 32'(cur_busy), 32'd0);
      check_eq("rst_done", 32'(cur_done), 32'd0);
      check_eq("rst_prod", cur_prod, 32'd0);
      check_eq("rst_step", cur_step, 32'd0);
    end
    sel4 = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    reset = 1'b0;
    last_prod[0] = 32'd0;
    last_prod[1] = 32'd0;
    idle_gap(2);

    run_op(16'h0F, 16'h0F, 0);
    run_op(16'hFF, 16'hFF, 0);
    run_op(16'h00, 16'hA5, 0);
    idle_gap(1);
    run_op(16'h12, 16'h34, 1);
    idle_gap(1);

    // abort mid-calculation: reset lands on the fourth iteration edge
    drive(1'b1, 16'hC8, 16'h03);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 16'hFF, 16'hFF);
      if (i == 3) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", 32'(cur_busy), 32'd0);
    check_eq("abort_done", 32'(cur_done), 32'd0);
    check_eq("abort_prod", cur_prod, 32'd0);
    check_eq("abort_step", cur_step, 32'd0);
    last_prod[0] = 32'd0;
    last_prod[1] = 32'd0;
    idle_gap(10);
    run_op(16'h07, 16'h06, 0);

    // start held high: back-to-back accepts every WIDTH+2 cycles
    run_op(16'h10, 16'h10, 2);
    run_op(16'h10, 16'h10, 2);
    run_op(16'h10, 16'h10, 0);

    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      if (n % 7 == 0) ra = 16'hFF;
      if (n % 11 == 0) rb = 16'h00;
      run_op(ra, rb, int'($urandom_range(0, 1)));
      idle_gap(int'($urandom_range(0, 2)));
    end

    sel4 = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    idle_gap(1);
    run_op(16'hF, 16'hD, 0);
    run_op(16'hF, 16'hF, 1);
    for (int n = 0; n < 10; n++) begin
      run_op(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), int'($urandom_range(0, 2)) == 1 ? 1 : 0);
      idle_gap(int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
